// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// IF stage of the 5-stage MIPS pipeline. Owns the program counter and the
// instruction memory, and drives the IF/ID bundle consumed by decode.
//
// The PC is a word index (+1 per instruction). Redirects arrive already
// formed as word addresses: jump / jump-register from decode, taken branch
// from execute. Fetching stops on HALT_WORD until a redirect clears it.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   enable               debug step/run enable; 0 freezes every register
//                        (program-load writes still land)
//   stall_flag           load-use stall from decode
//   flag_jump            J/JAL resolved in decode      (target in_pc_jump)
//   flag_jump_register   JR/JALR resolved in decode    (target in_pc_register)
//   flag_branch          taken branch from execute     (target in_pc_branch_target)
//   in_write_enable      program-load write strobe
//   in_write_addr        program-load word address
//   in_write_data        program-load word
//   out_pc_branch        IF/ID: PC+1 of the fetched instruction
//   out_instruccion      IF/ID: fetched instruction (0 = NOP)
//   out_pc               current PC
//   out_halt             sticky halt indicator
//
// Redirect priority, highest first:
//   branch > stall > jump-register > jump > halted > halt word > sequential
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int              len       = 32,
    parameter int              mem_depth = 256,
    parameter int              NB_addr   = $clog2(mem_depth),
    parameter logic [len-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               stall_flag,
    input  logic               flag_jump,
    input  logic               flag_jump_register,
    input  logic               flag_branch,
    input  logic [len-1:0]     in_pc_jump,
    input  logic [len-1:0]     in_pc_register,
    input  logic [len-1:0]     in_pc_branch_target,
    input  logic               in_write_enable,
    input  logic [NB_addr-1:0] in_write_addr,
    input  logic [len-1:0]     in_write_data,
    output logic [len-1:0]     out_pc_branch,
    output logic [len-1:0]     out_instruccion,
    output logic [len-1:0]     out_pc,
    output logic               out_halt
);

    // Instruction memory. Not reset: the program survives a CPU reset.
    logic [len-1:0] imem [mem_depth];

    logic [len-1:0] pc_q,        pc_d;
    logic [len-1:0] instr_q,     instr_d;
    logic [len-1:0] pc_branch_q, pc_branch_d;
    logic           halt_q,      halt_d;

    logic [len-1:0] fetch_word;
    logic [len-1:0] pc_plus_one;

    // Upper PC bits are ignored, so fetch addresses wrap modulo mem_depth.
    assign fetch_word  = imem[pc_q[NB_addr-1:0]];
    assign pc_plus_one = pc_q + len'(1);

    // Program-load port; independent of enable and halt. A read of the same
    // address in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (in_write_enable) begin
            imem[in_write_addr] <= in_write_data;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_branch_d = pc_branch_q;
        halt_d      = halt_q;

        if (enable) begin
            if (flag_branch) begin
                pc_d        = in_pc_branch_target;
                instr_d     = '0;
                pc_branch_d = '0;
                halt_d      = 1'b0;
            end else if (stall_flag) begin
                // Hold everything; decode re-presents any jump after the stall.
            end else if (flag_jump_register) begin
                pc_d        = in_pc_register;
                instr_d     = '0;
                pc_branch_d = '0;
                halt_d      = 1'b0;
            end else if (flag_jump) begin
                pc_d        = in_pc_jump;
                instr_d     = '0;
                pc_branch_d = '0;
                halt_d      = 1'b0;
            end else if (halt_q) begin
                // Halted: keep issuing NOPs, PC parked on the halt word.
                instr_d     = '0;
            end else if (fetch_word == HALT_WORD) begin
                instr_d     = HALT_WORD;
                pc_branch_d = pc_plus_one;
                halt_d      = 1'b1;
            end else begin
                instr_d     = fetch_word;
                pc_branch_d = pc_plus_one;
                pc_d        = pc_plus_one;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            instr_q     <= '0;
            pc_branch_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_branch_q <= pc_branch_d;
            halt_q      <= halt_d;
        end
    end

    assign out_pc          = pc_q;
    assign out_instruccion = instr_q;
    assign out_pc_branch   = pc_branch_q;
    assign out_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Stimulus is applied on the falling edge. Each applied cycle advances a
// behavioural model of the IF stage and pushes the expected post-edge
// outputs {pc, instruction, pc+1, halt} into exp_q; a monitor pops one entry
// after every rising edge and compares it with the DUT. Directed scenarios
// additionally check hand-derived constants.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int          LEN   = 32;
    localparam int          DEPTH = 256;
    localparam int          AW    = 8;
    localparam int          W     = 3 * LEN + 1;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            enable;
    logic            stall_flag;
    logic            flag_jump;
    logic            flag_jump_register;
    logic            flag_branch;
    logic [LEN-1:0]  in_pc_jump;
    logic [LEN-1:0]  in_pc_register;
    logic [LEN-1:0]  in_pc_branch_target;
    logic            in_write_enable;
    logic [AW-1:0]   in_write_addr;
    logic [LEN-1:0]  in_write_data;
    logic [LEN-1:0]  out_pc_branch;
    logic [LEN-1:0]  out_instruccion;
    logic [LEN-1:0]  out_pc;
    logic            out_halt;

    instruction_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .stall_flag          (stall_flag),
        .flag_jump           (flag_jump),
        .flag_jump_register  (flag_jump_register),
        .flag_branch         (flag_branch),
        .in_pc_jump          (in_pc_jump),
        .in_pc_register      (in_pc_register),
        .in_pc_branch_target (in_pc_branch_target),
        .in_write_enable     (in_write_enable),
        .in_write_addr       (in_write_addr),
        .in_write_data       (in_write_data),
        .out_pc_branch       (out_pc_branch),
        .out_instruccion     (out_instruccion),
        .out_pc              (out_pc),
        .out_halt            (out_halt)
    );

    // ---------------- staged stimulus ----------------
    logic            s_reset, s_enable, s_stall, s_jump, s_jr, s_br, s_we;
    logic [LEN-1:0]  s_tj, s_tr, s_tb, s_wd;
    logic [AW-1:0]   s_wa;

    // ---------------- reference model / scoreboard ----------------
    logic [LEN-1:0]  mem_m [DEPTH];
    logic [LEN-1:0]  pc_m, ins_m, pcb_m;
    logic            halt_m;
    logic [W-1:0]    exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pc_m   = '0;
        ins_m  = '0;
        pcb_m  = '0;
        halt_m = 1'b0;
    endtask

    // One clock of the IF stage, written straight from the priority rules.
    task automatic model_step();
        logic [LEN-1:0] word;
        word = mem_m[pc_m % DEPTH];
        if (s_enable) begin
            if (s_br) begin
                pc_m = s_tb; ins_m = 0; pcb_m = 0; halt_m = 0;
            end else if (s_stall) begin
                // nothing moves
            end else if (s_jr || s_jump) begin
                pc_m = s_jr ? s_tr : s_tj; ins_m = 0; pcb_m = 0; halt_m = 0;
            end else if (halt_m) begin
                ins_m = 0;
            end else if (word == HALT) begin
                ins_m = HALT; pcb_m = pc_m + 1; halt_m = 1;
            end else begin
                ins_m = word; pcb_m = pc_m + 1; pc_m = pc_m + 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        reset               = s_reset;
        enable              = s_enable;
        stall_flag          = s_stall;
        flag_jump           = s_jump;
        flag_jump_register  = s_jr;
        flag_branch         = s_br;
        in_pc_jump          = s_tj;
        in_pc_register      = s_tr;
        in_pc_branch_target = s_tb;
        in_write_enable     = s_we;
        in_write_addr       = s_wa;
        in_write_data       = s_wd;
        if (s_reset) begin
            model_step();
            exp_q.push_back({pc_m, ins_m, pcb_m, halt_m});
        end
        // Memory write lands after the fetch of this cycle saw the old word.
        if (s_we) mem_m[s_wa] = s_wd;
    endtask

    task automatic clear_flags();
        s_stall = 0; s_jump = 0; s_jr = 0; s_br = 0; s_we = 0;
    endtask

    // Directed check of the outputs after the next rising edge.
    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pcb, input logic h);
        @(posedge clk);
        #2;
        check32({tag, "_pc"},   out_pc,          pc);
        check32({tag, "_ins"},  out_instruccion, ins);
        check32({tag, "_pcb"},  out_pc_branch,   pcb);
        check32({tag, "_halt"}, {31'd0, out_halt}, {31'd0, h});
    endtask

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'($urandom_range(0, 300));
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("sb_pc",   out_pc,            e[W-1 -: 32]);
            check32("sb_ins",  out_instruccion,   e[W-33 -: 32]);
            check32("sb_pcb",  out_pc_branch,     e[32:1]);
            check32("sb_halt", {31'd0, out_halt}, {31'd0, e[0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;

        s_reset = 0; s_enable = 0; s_tj = 0; s_tr = 0; s_tb = 0; s_wa = 0; s_wd = 0;
        clear_flags();
        reset = 0; enable = 0; stall_flag = 0; flag_jump = 0; flag_jump_register = 0;
        flag_branch = 0; in_pc_jump = 0; in_pc_register = 0; in_pc_branch_target = 0;
        in_write_enable = 0; in_write_addr = 0; in_write_data = 0;
        model_reset();

        // Reset state.
        #2;
        check32("rst_pc",   out_pc,          32'd0);
        check32("rst_ins",  out_instruccion, 32'd0);
        check32("rst_pcb",  out_pc_branch,   32'd0);
        check32("rst_halt", {31'd0, out_halt}, 32'd0);

        // Program load under reset.
        for (int a = 0; a < DEPTH; a++) begin
            d = $urandom;
            if (d == HALT) d = 32'd0;
            case (a)
                0:  d = 32'd11;
                1:  d = 32'd22;
                2:  d = 32'd33;
                3:  d = 32'd44;
                10: d = 32'hAA;
                default: ;
            endcase
            s_we = 1; s_wa = AW'(a); s_wd = d;
            tick();
        end
        s_we = 0;

        // Sequential fetch.
        s_reset = 1; s_enable = 1;
        tick(); expect_out("seq0", 1, 32'd11, 1, 0);
        tick(); expect_out("seq1", 2, 32'd22, 2, 0);

        // Stall holds for two cycles, then fetch resumes.
        s_stall = 1;
        tick(); expect_out("stall0", 2, 32'd22, 2, 0);
        tick(); expect_out("stall1", 2, 32'd22, 2, 0);
        s_stall = 0;
        tick(); expect_out("seq2", 3, 32'd33, 3, 0);
        tick(); expect_out("seq3", 4, 32'd44, 4, 0);

        // Jump under stall does nothing; jump alone flushes and redirects.
        s_jump = 1; s_tj = 10; s_stall = 1;
        tick(); expect_out("jstall", 4, 32'd44, 4, 0);
        s_stall = 0;
        tick(); expect_out("jump", 10, 32'd0, 0, 0);
        s_jump = 0;
        tick(); expect_out("jtgt", 11, 32'hAA, 11, 0);

        // Branch beats stall and jump.
        s_br = 1; s_tb = 5; s_jump = 1; s_stall = 1;
        tick(); expect_out("brprio", 5, 32'd0, 0, 0);
        clear_flags();

        // Jump-register beats jump.
        s_jr = 1; s_tr = 20; s_jump = 1; s_tj = 30;
        tick(); expect_out("jrprio", 20, 32'd0, 0, 0);
        clear_flags();

        // Halt: place HALT at 3, branch there, watch it stick, branch out.
        s_br = 1; s_tb = 3; s_we = 1; s_wa = 3; s_wd = HALT;
        tick(); expect_out("hbr", 3, 32'd0, 0, 0);
        clear_flags();
        tick(); expect_out("halt0", 3, HALT, 4, 1);
        tick(); expect_out("halt1", 3, 32'd0, 4, 1);
        s_br = 1; s_tb = 0;
        tick(); expect_out("hclr", 0, 32'd0, 0, 0);
        clear_flags();
        tick(); expect_out("restart", 1, 32'd11, 1, 0);

        // Freeze: nothing moves while a write lands.
        s_enable = 0; s_we = 1; s_wa = 1; s_wd = 32'h55;
        tick(); expect_out("frz0", 1, 32'd11, 1, 0);
        s_we = 0;
        tick(); expect_out("frz1", 1, 32'd11, 1, 0);
        tick(); expect_out("frz2", 1, 32'd11, 1, 0);
        s_enable = 1;
        tick(); expect_out("frzwr", 2, 32'h55, 2, 0);

        // PC wrap: 32'hFFFFFFFF + 1 = 0, fetch from word 255.
        s_br = 1; s_tb = 32'hFFFFFFFF;
        tick(); expect_out("wrapbr", 32'hFFFFFFFF, 32'd0, 0, 0);
        clear_flags();
        tick(); expect_out("wrap", 0, mem_m[DEPTH-1], 0, 0);

        // Randomized run with an asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            s_enable = ($urandom_range(0, 99) < 90);
            s_br     = ($urandom_range(0, 99) < 6);
            s_stall  = ($urandom_range(0, 99) < 10);
            s_jr     = ($urandom_range(0, 99) < 5);
            s_jump   = ($urandom_range(0, 99) < 5);
            s_tb     = pick_target();
            s_tr     = pick_target();
            s_tj     = pick_target();
            s_we     = ($urandom_range(0, 99) < 15);
            s_wa     = AW'($urandom_range(0, DEPTH - 1));
            s_wd     = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
            tick();
            if (n == 700) begin
                @(posedge clk);
                #3;
                s_reset = 0;
                reset   = 0;
                model_reset();
                #1;
                check32("arst_pc",   out_pc,          32'd0);
                check32("arst_ins",  out_instruccion, 32'd0);
                check32("arst_pcb",  out_pc_branch,   32'd0);
                check32("arst_halt", {31'd0, out_halt}, 32'd0);
                clear_flags();
                tick();
                expect_out("arst_hold", 0, 32'd0, 0, 0);
                s_reset = 1;
            end
        end

        clear_flags();
        s_enable = 0;
        repeat (3) @(posedge clk);
        #2;
        check32("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the PC and the instruction memory, including a program-load write port used by the debug unit.
- Drives the IF/ID bundle consumed by the decode stage: in_pc_branch (= PC+1) and in_instruccion.
- Takes redirect requests from decode (jump, jump-register) and from execute (taken branch), plus the decode stall_flag.
- PC is a word index: +1 per instruction. Jump targets arrive already formed as word addresses.

Parameters:
- len, 32, datapath/instruction width
- mem_depth, 256, instruction memory depth in words
- NB_addr, $clog2(mem_depth), memory index width
- HALT_WORD, 32'hFFFFFFFF, halt instruction encoding

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  debug step/run enable; 0 freezes all state except memory writes
- stall_flag  in  1  load-use stall from decode
- flag_jump  in  1  J/JAL resolved in decode
- flag_jump_register  in  1  JR/JALR resolved in decode
- flag_branch  in  1  taken branch resolved in execute
- in_pc_jump  in  len  jump target from decode
- in_pc_register  in  len  register target (rs) from decode
- in_pc_branch_target  in  len  branch target from execute
- in_write_enable  in  1  program-load write strobe
- in_write_addr  in  NB_addr  program-load word address
- in_write_data  in  len  program-load word
- out_pc_branch  out  len  IF/ID: PC+1 of the fetched instruction
- out_instruccion  out  len  IF/ID: fetched instruction (0 = NOP)
- out_pc  out  len  current PC (debug visibility)
- out_halt  out  1  sticky halt indicator

Behaviour:
- Reset (async, reset=0):
  - pc, out_pc_branch, out_instruccion = 0; out_halt = 0.
  - Memory contents are unaffected.
- Memory read: combinational, imem[pc[NB_addr-1:0]]. Upper PC bits are ignored, so addresses wrap modulo mem_depth.
- Memory write: synchronous on clk when in_write_enable=1, independent of enable and halt.
  - A same-cycle read of the same address returns the old word.
- All register updates below occur only when enable=1; otherwise every register holds.
- Per-cycle priority, highest first:
  1. flag_branch: pc <= in_pc_branch_target; out_instruccion <= 0; out_pc_branch <= 0; out_halt <= 0.
  2. stall_flag: pc, out_instruccion and out_pc_branch all hold. Stall dominates jumps, because decode re-presents the jump after the stall.
  3. flag_jump_register: pc <= in_pc_register; out_instruccion <= 0 (flush the wrong-path fetch); out_pc_branch <= 0; out_halt <= 0.
  4. flag_jump: same as 3, with target in_pc_jump.
  5. out_halt=1: pc holds; out_instruccion <= 0; out_pc_branch holds.
  6. Fetched word == HALT_WORD: out_instruccion <= HALT_WORD; out_pc_branch <= pc+1; pc holds; out_halt <= 1.
  7. Normal: out_instruccion <= imem[pc]; out_pc_branch <= pc+1; pc <= pc+1.
- Both jump flags asserted together: jump-register wins.
- Latency: an instruction at address A appears on out_instruccion one cycle after pc==A. A redirect loads the target into pc on that edge, and the target instruction appears one cycle later.
- Arithmetic: pc+1 is len-bit modular, so 32'hFFFFFFFF+1 = 0.
- out_pc is always the pc register value.

Test Plan:
- Sequential fetch: load imem[0..3] = 11,22,33,44; release reset; enable=1. Required: out_instruccion 11,22,33,44 on consecutive cycles, out_pc_branch 1,2,3,4.
- Stall: assert stall_flag for 2 cycles while out_instruccion=22. Required: out_instruccion=22, out_pc_branch=2 and pc=2 hold for 2 cycles, then 33 follows.
- Jump flush: flag_jump=1, in_pc_jump=10, imem[10]=0xAA. Required: next out_instruccion=0 and pc=10, then out_instruccion=0xAA with out_pc_branch=11. With stall_flag also high, no redirect occurs.
- Branch priority: flag_branch=1 (target 5), flag_jump=1 and stall_flag=1 in the same cycle. Required: pc=5, out_instruccion=0.
- Halt: imem[3]=HALT_WORD. Required: out_instruccion=HALT_WORD, out_halt=1, pc stays 3, NOPs follow. A later flag_branch (target 0) clears out_halt and restarts fetch at 0.
- Reset/freeze: with enable=0 over 3 cycles, no output changes while an in_write_enable write lands. Asserting reset mid-run forces all outputs to 0 immediately, without waiting for a clock edge.
